// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with a DIRECT (decoded select) mode
// and a SCAN mode that walks one active line across all outputs.
module onehot_scan_decoder #(
    parameter int N_OUT   = 6,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N_OUT-1:0]   out,
    output logic [SEL_W-1:0]   idx,
    output logic               err,
    output logic               wrap
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Extra bit so the range check also works when N_OUT == 2**SEL_W.
    localparam logic [SEL_W:0]   N_OUT_EXT = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(N_OUT - 1);

    state_t               state_reg, state_next;
    logic [N_OUT-1:0]     out_reg, out_next;
    logic [SEL_W-1:0]     idx_reg, idx_next;
    logic                 err_reg, err_next;
    logic                 wrap_reg, wrap_next;
    logic [DWELL_W-1:0]   dwell_cnt_reg, dwell_cnt_next;

    logic [SEL_W-1:0]     idx_adv;
    logic                 sel_in_range;
    logic [N_OUT-1:0]     sel_dec;
    logic [N_OUT-1:0]     adv_dec;

    assign idx_adv      = (idx_reg == LAST_IDX) ? '0 : idx_reg + SEL_W'(1);
    assign sel_in_range = ({1'b0, sel} < N_OUT_EXT);

    // Only lines 0..N_OUT-1 exist, so out-of-range codes can never reach out.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
            assign sel_dec[gi] = (sel == SEL_W'(gi));
            assign adv_dec[gi] = (idx_adv == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_OFF;
            out_reg       <= '0;
            idx_reg       <= '0;
            err_reg       <= 1'b0;
            wrap_reg      <= 1'b0;
            dwell_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            out_reg       <= out_next;
            idx_reg       <= idx_next;
            err_reg       <= err_next;
            wrap_reg      <= wrap_next;
            dwell_cnt_reg <= dwell_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        out_next       = out_reg;
        idx_next       = idx_reg;
        err_next       = err_reg;
        wrap_next      = 1'b0;
        dwell_cnt_next = dwell_cnt_reg;

        if (!en) begin
            state_next = ST_OFF;
        end else if (mode) begin
            state_next = ST_SCAN;
        end else begin
            state_next = ST_DIRECT;
        end

        // Outputs are decided by the state being entered, so a mode change
        // takes effect on the same edge and any partial dwell is dropped.
        case (state_next)
            ST_OFF: begin
                out_next       = '0;
                err_next       = 1'b0;
                dwell_cnt_next = '0;
            end
            ST_DIRECT: begin
                dwell_cnt_next = '0;
                if (state_reg != ST_DIRECT) begin
                    out_next = '0;
                    err_next = 1'b0;
                end else if (sel_valid) begin
                    if (sel_in_range) begin
                        out_next = sel_dec;
                        idx_next = sel;
                        err_next = 1'b0;
                    end else begin
                        out_next = '0;
                        err_next = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                err_next = 1'b0;
                if (state_reg != ST_SCAN) begin
                    idx_next       = '0;
                    out_next       = N_OUT'(1);
                    dwell_cnt_next = '0;
                end else if (dwell_cnt_reg >= dwell) begin
                    // >= rather than == so a live drop of dwell forces the step.
                    dwell_cnt_next = '0;
                    idx_next       = idx_adv;
                    out_next       = adv_dec;
                    wrap_next      = (idx_reg == LAST_IDX);
                end else begin
                    dwell_cnt_next = dwell_cnt_reg + DWELL_W'(1);
                end
            end
            default: begin
                out_next       = '0;
                dwell_cnt_next = '0;
            end
        endcase
    end

    assign out  = out_reg;
    assign idx  = idx_reg;
    assign err  = err_reg;
    assign wrap = wrap_reg;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder (N_OUT=6, SEL_W=3, DWELL_W=8);
// outputs are sampled 1ns after the rising edge.
module tb_onehot_scan_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic       sel_valid;
    logic [7:0] dwell;
    logic [5:0] out;
    logic [2:0] idx;
    logic       err;
    logic       wrap;

    int n_checks = 0;
    int n_errors = 0;

    onehot_scan_decoder #(
        .N_OUT   (6),
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .sel_valid (sel_valid),
        .dwell     (dwell),
        .out       (out),
        .idx       (idx),
        .err       (err),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        sel_valid = 1'b0;
        dwell     = '0;
        step();
        step();
        check("rst_out", 32'(out), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        rst_n = 1'b1;

        // DIRECT: entry edge drives nothing
        en = 1'b1; mode = 1'b0;
        step();
        check("dir_entry_out", 32'(out), 32'h0);
        sel = 3'd5; sel_valid = 1'b1;
        step();
        check("dir_s5_out", 32'(out), 32'h20);
        check("dir_s5_idx", 32'(idx), 32'd5);
        check("dir_s5_err", 32'(err), 32'h0);
        sel = 3'd6;
        step();
        check("dir_s6_out", 32'(out), 32'h0);
        check("dir_s6_err", 32'(err), 32'h1);
        check("dir_s6_idx", 32'(idx), 32'd5);
        sel_valid = 1'b0;
        step();
        check("dir_hold_err", 32'(err), 32'h1);
        check("dir_hold_out", 32'(out), 32'h0);
        sel = 3'd2; sel_valid = 1'b1;
        step();
        check("dir_s2_out", 32'(out), 32'h04);
        check("dir_s2_idx", 32'(idx), 32'd2);
        check("dir_s2_err", 32'(err), 32'h0);
        sel = 3'd7;
        step();
        check("dir_s7_err", 32'(err), 32'h1);
        check("dir_s7_idx", 32'(idx), 32'd2);
        sel_valid = 1'b0;

        // SCAN dwell=2: each line held 3 cycles, wrap every 18
        dwell = 8'd2; mode = 1'b1;
        step();
        check("scan_entry_idx", 32'(idx), 32'd0);
        check("scan_entry_out", 32'(out), 32'h01);
        check("scan_entry_err", 32'(err), 32'h0);
        for (int k = 1; k <= 19; k++) begin
            step();
            check("scan_idx", 32'(idx), 32'((k / 3) % 6));
            check("scan_out", 32'(out), 32'(1 << ((k / 3) % 6)));
            check("scan_wrap", 32'(wrap), 32'(k % 18 == 0));
        end

        // dwell=0: rotate every cycle (idx 0, dwell_cnt 1 here)
        dwell = 8'd0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("fast_idx", 32'(idx), 32'(k % 6));
            check("fast_out", 32'(out), 32'(1 << (k % 6)));
            check("fast_wrap", 32'(wrap), 32'(k == 6));
        end

        // dwell 7 -> 1 while dwell_cnt=5 forces advance next edge
        dwell = 8'd7;
        for (int k = 0; k < 5; k++) step();
        check("live_pre_idx", 32'(idx), 32'd1);
        dwell = 8'd1;
        step();
        check("live_adv_idx", 32'(idx), 32'd2);
        check("live_adv_out", 32'(out), 32'h04);

        // en drop at idx=4
        dwell = 8'd0;
        step();
        step();
        check("endrop_pre_idx", 32'(idx), 32'd4);
        en = 1'b0;
        step();
        check("endrop_out", 32'(out), 32'h0);
        check("endrop_idx", 32'(idx), 32'd4);
        step();
        check("off_hold_idx", 32'(idx), 32'd4);
        en = 1'b1; mode = 1'b1;
        step();
        check("restart_idx", 32'(idx), 32'd0);
        check("restart_out", 32'(out), 32'h01);

        // asynchronous reset mid-scan at idx=3
        step();
        step();
        step();
        check("prerst_idx", 32'(idx), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out), 32'h0);
        check("async_rst_idx", 32'(idx), 32'd0);
        check("async_rst_err", 32'(err), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_out", 32'(out), 32'h01);

        // SCAN -> DIRECT with a valid sel on the mode-change edge
        mode = 1'b0; sel = 3'd1; sel_valid = 1'b1;
        step();
        check("s2d_entry_out", 32'(out), 32'h0);
        step();
        check("s2d_sel1_out", 32'(out), 32'h02);
        check("s2d_sel1_idx", 32'(idx), 32'd1);
        sel_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
